// File: rtl/count_chk_pkg.sv
// Shared types for the count sequence checker.
package count_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        TRACK,
        LOCKED
    } chk_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter. A clear and an increment on the same edge leaves the count at 1.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;
    logic         w_full;

    assign w_full = &r_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= i_inc ? W'(1) : '0;
        end else if (i_inc && !w_full) begin
            r_q <= r_q + W'(1);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/count_seq_checker.sv
// Sequence monitor for a free-running up-counter: locks onto the stream and
// flags every break in sequence once locked, keeping a saturating error count.
module count_seq_checker
    import count_chk_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STEP   = 1,
    parameter int unsigned LOCK_N = 4,
    parameter int unsigned ERRW   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_cnt_vld,
    input  logic [WIDTH-1:0] i_cnt_in,
    input  logic             i_clr_err,
    output logic             o_lock,
    output logic             o_err,
    output logic [ERRW-1:0]  o_err_cnt,
    output logic [WIDTH-1:0] o_exp_cnt
);

    localparam int unsigned RUN_W = $clog2(LOCK_N + 1);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_N);

    chk_state_t       r_state;
    logic [RUN_W-1:0] r_run;
    logic [WIDTH-1:0] r_exp;
    logic             r_lock;
    logic             r_err;

    logic [WIDTH-1:0] w_next_exp;
    logic [RUN_W-1:0] w_run_inc;
    logic             w_match;
    logic             w_err_inc;

    assign w_next_exp = i_cnt_in + STEP_W;
    assign w_run_inc  = r_run + RUN_W'(1);
    assign w_match    = (i_cnt_in == r_exp);
    // Disabling the checker takes priority over a mismatch seen on the same edge.
    assign w_err_inc  = i_en && i_cnt_vld && (r_state == LOCKED) && !w_match;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_run   <= '0;
            r_exp   <= '0;
            r_lock  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (!i_en) begin
                r_state <= IDLE;
                r_lock  <= 1'b0;
                r_run   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= ACQUIRE;
                    end
                    ACQUIRE: begin
                        if (i_cnt_vld) begin
                            r_exp   <= w_next_exp;
                            r_run   <= '0;
                            r_state <= TRACK;
                        end
                    end
                    TRACK: begin
                        if (i_cnt_vld) begin
                            // A mismatch simply rebases the run on the new value.
                            r_exp <= w_next_exp;
                            if (w_match) begin
                                r_run <= w_run_inc;
                                if (w_run_inc == LOCK_RUN) begin
                                    r_state <= LOCKED;
                                    r_lock  <= 1'b1;
                                end
                            end else begin
                                r_run <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (i_cnt_vld) begin
                            r_exp <= w_next_exp;
                            if (!w_match) begin
                                r_err   <= 1'b1;
                                r_lock  <= 1'b0;
                                r_run   <= '0;
                                r_state <= TRACK;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .W (ERRW)
    ) u_err_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_clr_err),
        .i_inc   (w_err_inc),
        .o_q     (o_err_cnt)
    );

    assign o_lock    = r_lock;
    assign o_err     = r_err;
    assign o_exp_cnt = r_exp;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed, table-driven bench for count_seq_checker, plus a saturation run on a narrow error counter.
module tb_count_seq_checker;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       vld;
        logic [3:0] cnt;
        logic       clr;
        logic       lock;
        logic       err;
        logic [7:0] ec;
        logic       chk_exp;
        logic [3:0] exp_v;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst_n, a_en, a_vld, a_clr;
    logic [3:0] a_cnt;
    logic       a_lock, a_err;
    logic [7:0] a_ec;
    logic [3:0] a_exp;

    logic       b_rst_n, b_en, b_vld, b_clr;
    logic [3:0] b_cnt;
    logic       b_lock, b_err;
    logic [1:0] b_ec;
    logic [3:0] b_exp;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    count_seq_checker #(
        .WIDTH (4), .STEP (1), .LOCK_N (4), .ERRW (8)
    ) u_dut_a (
        .i_clk     (clk),
        .i_rst_n   (a_rst_n),
        .i_en      (a_en),
        .i_cnt_vld (a_vld),
        .i_cnt_in  (a_cnt),
        .i_clr_err (a_clr),
        .o_lock    (a_lock),
        .o_err     (a_err),
        .o_err_cnt (a_ec),
        .o_exp_cnt (a_exp)
    );

    count_seq_checker #(
        .WIDTH (4), .STEP (1), .LOCK_N (4), .ERRW (2)
    ) u_dut_b (
        .i_clk     (clk),
        .i_rst_n   (b_rst_n),
        .i_en      (b_en),
        .i_cnt_vld (b_vld),
        .i_cnt_in  (b_cnt),
        .i_clr_err (b_clr),
        .o_lock    (b_lock),
        .o_err     (b_err),
        .o_err_cnt (b_ec),
        .o_exp_cnt (b_exp)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic add(input logic rst_n, input logic en, input logic vld, input logic [3:0] cnt,
                       input logic clr, input logic lock, input logic err, input logic [7:0] ec,
                       input logic chk_exp, input logic [3:0] exp_v);
        vec_t v;
        v.rst_n = rst_n; v.en = en; v.vld = vld; v.cnt = cnt; v.clr = clr;
        v.lock = lock; v.err = err; v.ec = ec; v.chk_exp = chk_exp; v.exp_v = exp_v;
        vecs.push_back(v);
    endtask

    // Drive one sample into the narrow-counter instance and return after its response settles.
    task automatic b_step(input logic en, input logic vld, input logic [3:0] cnt);
        b_en = en; b_vld = vld; b_cnt = cnt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] cur;
        logic [1:0] want_ec;

        a_rst_n = 1'b0; a_en = 1'b0; a_vld = 1'b0; a_cnt = '0; a_clr = 1'b0;
        b_rst_n = 1'b0; b_en = 1'b0; b_vld = 1'b0; b_cnt = '0; b_clr = 1'b0;

        // Reset state
        add(0, 0, 0, 4'd0, 0, 0, 0, 8'd0, 1, 4'd0);
        add(0, 1, 1, 4'd9, 1, 0, 0, 8'd0, 1, 4'd0);
        // Lock acquisition and wrap
        add(1, 1, 0, 4'd0, 0, 0, 0, 8'd0, 1, 4'd0);
        for (int i = 0; i < 22; i++)
            add(1, 1, 1, 4'(i), 0, (i >= 4), 0, 8'd0, 1, 4'(i + 1));
        // Locked mismatch then relock
        add(1, 1, 1, 4'd7, 0, 0, 1, 8'd1, 1, 4'd8);
        for (int i = 8; i < 12; i++)
            add(1, 1, 1, 4'(i), 0, (i == 11), 0, 8'd1, 1, 4'(i + 1));
        // Walk round to 9, then bubbles with junk data
        for (int i = 12; i < 26; i++)
            add(1, 1, 1, 4'(i), 0, 1, 0, 8'd1, 1, 4'(i + 1));
        add(1, 1, 0, 4'd3, 0, 1, 0, 8'd1, 1, 4'd10);
        add(1, 1, 0, 4'd15, 0, 1, 0, 8'd1, 1, 4'd10);
        add(1, 1, 0, 4'd9, 0, 1, 0, 8'd1, 1, 4'd10);
        add(1, 1, 1, 4'd10, 0, 1, 0, 8'd1, 1, 4'd11);
        // Second error, relock, then clear coinciding with a mismatch
        add(1, 1, 1, 4'd4, 0, 0, 1, 8'd2, 1, 4'd5);
        for (int i = 5; i < 9; i++)
            add(1, 1, 1, 4'(i), 0, (i == 8), 0, 8'd2, 1, 4'(i + 1));
        add(1, 1, 1, 4'd0, 1, 0, 1, 8'd1, 1, 4'd1);
        add(1, 1, 1, 4'd1, 0, 0, 0, 8'd1, 1, 4'd2);
        // Disable retains err_cnt; clear on its own
        add(1, 0, 1, 4'd2, 0, 0, 0, 8'd1, 0, 4'd0);
        add(1, 0, 0, 4'd0, 1, 0, 0, 8'd0, 0, 4'd0);
        // Build err_cnt=2 while locked, then reset
        add(1, 1, 0, 4'd0, 0, 0, 0, 8'd0, 0, 4'd0);
        for (int i = 0; i < 5; i++)
            add(1, 1, 1, 4'(i), 0, (i == 4), 0, 8'd0, 1, 4'(i + 1));
        add(1, 1, 1, 4'd9, 0, 0, 1, 8'd1, 1, 4'd10);
        for (int i = 10; i < 14; i++)
            add(1, 1, 1, 4'(i), 0, (i == 13), 0, 8'd1, 1, 4'(i + 1));
        add(1, 1, 1, 4'd0, 0, 0, 1, 8'd2, 1, 4'd1);
        for (int i = 1; i < 5; i++)
            add(1, 1, 1, 4'(i), 0, (i == 4), 0, 8'd2, 1, 4'(i + 1));
        add(0, 1, 1, 4'd5, 0, 0, 0, 8'd0, 1, 4'd0);
        // Back in IDLE: first sample after reset is not captured
        add(1, 1, 1, 4'd6, 0, 0, 0, 8'd0, 1, 4'd0);
        add(1, 1, 1, 4'd6, 0, 0, 0, 8'd0, 1, 4'd7);
        add(1, 1, 1, 4'd7, 0, 0, 0, 8'd0, 1, 4'd8);

        foreach (vecs[k]) begin
            a_rst_n = vecs[k].rst_n; a_en = vecs[k].en; a_vld = vecs[k].vld;
            a_cnt = vecs[k].cnt; a_clr = vecs[k].clr;
            @(posedge clk);
            #1;
            check($sformatf("v%0d lock", k), 32'(a_lock), 32'(vecs[k].lock));
            check($sformatf("v%0d err", k), 32'(a_err), 32'(vecs[k].err));
            check($sformatf("v%0d err_cnt", k), 32'(a_ec), 32'(vecs[k].ec));
            if (vecs[k].chk_exp)
                check($sformatf("v%0d exp_cnt", k), 32'(a_exp), 32'(vecs[k].exp_v));
        end

        // Narrow error counter: five locked mismatches, count sticks at all-ones.
        b_step(1'b0, 1'b0, 4'd0);
        b_rst_n = 1'b1;
        b_step(1'b1, 1'b0, 4'd0);
        cur = 4'd0;
        b_step(1'b1, 1'b1, cur);
        for (int k = 1; k <= 5; k++) begin
            for (int j = 1; j <= 4; j++) begin
                cur = cur + 4'd1;
                b_step(1'b1, 1'b1, cur);
            end
            check($sformatf("sat%0d relock", k), 32'(b_lock), 32'd1);
            cur = cur + 4'd3;
            b_step(1'b1, 1'b1, cur);
            want_ec = (k >= 3) ? 2'd3 : 2'(k);
            check($sformatf("sat%0d err", k), 32'(b_err), 32'd1);
            check($sformatf("sat%0d err_cnt", k), 32'(b_ec), 32'(want_ec));
            check($sformatf("sat%0d lock", k), 32'(b_lock), 32'd0);
        end
        cur = cur + 4'd1;
        b_step(1'b1, 1'b1, cur);
        check("sat err_single_cycle", 32'(b_err), 32'd0);
        check("sat err_cnt_hold", 32'(b_ec), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
